// File: rtl/cv32e40s_rf_ecc_scrubber.sv
// rtl/cv32e40s_rf_ecc_scrubber.sv - background ECC scrubber for the integer register file read side
module cv32e40s_rf_ecc_scrubber #(
    parameter int INTERVAL_W = 16,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scrub_en_i,
    input  logic [INTERVAL_W-1:0] interval_i,
    output logic                  rreq_o,
    output logic [4:0]            raddr_o,
    input  logic                  port_gnt_i,
    input  logic [37:0]           rdata_i,
    output logic                  err_o,
    output logic [4:0]            err_addr_o,
    output logic [ERR_CNT_W-1:0]  err_cnt_o,
    output logic                  alert_major_o
);

    typedef enum logic [1:0] {IDLE, COUNT, REQ, CHECK} state_e;

    // Write-path check-bit encoder; odd check bits are stored inverted so all-zero words are invalid.
    function automatic logic [5:0] rf_ecc_encode(input logic [31:0] d);
        logic [5:0] c;
        c[0] = ^(d & 32'h2606_BD25);
        c[1] = ^(d & 32'hDEBA_8050);
        c[2] = ^(d & 32'h413D_89AA);
        c[3] = ^(d & 32'h3123_4ED1);
        c[4] = ^(d & 32'hC2C1_323B);
        c[5] = ^(d & 32'h2DCC_624C);
        return c ^ 6'b10_1010;
    endfunction

    state_e                state_q, state_d;
    logic [4:0]            ptr_q;
    logic [INTERVAL_W-1:0] cnt_q, cnt_d;
    logic [37:0]           cap_q;
    logic [4:0]            err_addr_q;
    logic [ERR_CNT_W-1:0]  err_cnt_q;
    logic [5:0]            syndrome;
    logic                  capture;
    logic                  check;
    logic                  word_err;

    assign syndrome = rf_ecc_encode(cap_q[31:0]) ^ cap_q[37:32];
    assign word_err = |syndrome;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        check   = 1'b0;
        case (state_q)
            IDLE: begin
                if (scrub_en_i) begin
                    cnt_d   = interval_i;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (!scrub_en_i) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = REQ;
                end else begin
                    cnt_d = cnt_q - INTERVAL_W'(1);
                end
            end
            REQ: begin
                // Disable wins over a simultaneous grant: the request is simply dropped.
                if (!scrub_en_i) begin
                    state_d = IDLE;
                end else if (port_gnt_i) begin
                    capture = 1'b1;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                check = 1'b1;
                cnt_d = interval_i;
                state_d = scrub_en_i ? COUNT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ptr_q      <= '0;
            cap_q      <= '0;
            err_addr_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                cap_q <= rdata_i;
            end
            if (check) begin
                ptr_q <= ptr_q + 5'd1;
                if (word_err) begin
                    err_addr_q <= ptr_q;
                    if (err_cnt_q != '1) begin
                        err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
                    end
                end
            end
        end
    end

    assign rreq_o        = (state_q == REQ);
    assign raddr_o       = ptr_q;
    assign err_o         = check && word_err;
    assign alert_major_o = check && word_err;
    assign err_addr_o    = err_addr_q;
    assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_cv32e40s_rf_ecc_scrubber.sv
// tb/tb_cv32e40s_rf_ecc_scrubber.sv - self-checking bench for the register file ECC scrubber
module tb_cv32e40s_rf_ecc_scrubber;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scrub_en_i = 1'b0;
    logic [15:0] interval_i = '0;
    logic        rreq_o;
    logic [4:0]  raddr_o;
    logic        port_gnt_i = 1'b0;
    logic [37:0] rdata_i = '0;
    logic        err_o;
    logic [4:0]  err_addr_o;
    logic [7:0]  err_cnt_o;
    logic        alert_major_o;

    cv32e40s_rf_ecc_scrubber #(.INTERVAL_W(16), .ERR_CNT_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .scrub_en_i    (scrub_en_i),
        .interval_i    (interval_i),
        .rreq_o        (rreq_o),
        .raddr_o       (raddr_o),
        .port_gnt_i    (port_gnt_i),
        .rdata_i       (rdata_i),
        .err_o         (err_o),
        .err_addr_o    (err_addr_o),
        .err_cnt_o     (err_cnt_o),
        .alert_major_o (alert_major_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Check bits computed bit by bit from the column masks, including the inversion pattern.
    logic [31:0] masks [6] = '{32'h2606_BD25, 32'hDEBA_8050, 32'h413D_89AA,
                               32'h3123_4ED1, 32'hC2C1_323B, 32'h2DCC_624C};
    function automatic logic [5:0] enc(input logic [31:0] d);
        logic [5:0] e;
        for (int i = 0; i < 6; i++) begin
            int ones = 0;
            for (int b = 0; b < 32; b++) begin
                if (masks[i][b] && d[b]) ones++;
            end
            e[i] = ((ones % 2) == 1) ^ (i % 2 == 1);
        end
        return e;
    endfunction

    // Timeline model: absolute cycle numbers for the next request and the pending check.
    int          cyc = 0;
    bit          m_active;
    int          m_req_at;
    int          m_check_at;
    logic [37:0] m_word;
    int          m_ptr, m_eaddr, m_cnt;
    logic        e_rreq, e_err;

    task automatic model_eval();
        e_rreq = m_active && (cyc >= m_req_at);
        e_err  = (m_check_at == cyc) && (enc(m_word[31:0]) != m_word[37:32]);
    endtask

    task automatic model_reset();
        m_active = 0; m_req_at = 0; m_check_at = -1; m_word = '0;
        m_ptr = 0; m_eaddr = 0; m_cnt = 0;
        model_eval();
    endtask

    task automatic model_step();
        int cur = cyc;
        int n = int'(interval_i);
        if (m_check_at == cur) begin
            if (enc(m_word[31:0]) != m_word[37:32]) begin
                m_eaddr = m_ptr;
                if (m_cnt < 255) m_cnt++;
            end
            m_ptr = (m_ptr + 1) % 32;
            m_check_at = -1;
            m_active = scrub_en_i;
            m_req_at = cur + n + 2;
        end else if (!m_active) begin
            if (scrub_en_i) begin
                m_active = 1;
                m_req_at = cur + n + 2;
            end
        end else if (!scrub_en_i) begin
            m_active = 0;
        end else if (cur >= m_req_at && port_gnt_i) begin
            m_check_at = cur + 1;
            m_word = rdata_i;
            m_active = 0;
        end
        cyc = cur + 1;
        model_eval();
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("rreq_o", rreq_o, e_rreq);
            check("raddr_o", raddr_o, m_ptr[4:0]);
            check("err_o", err_o, e_err);
            check("alert_major_o", alert_major_o, e_err);
            check("err_addr_o", err_addr_o, m_eaddr[4:0]);
            check("err_cnt_o", err_cnt_o, m_cnt[7:0]);
        end
    end

    logic [37:0] word_good = 38'h2A_0000_0000;
    logic [37:0] word_bad  = 38'h2A_0000_0001;
    logic [4:0]  bad_addr  = 5'd5;
    bit          use_bad   = 0;

    task automatic tick();
        @(negedge clk);
        #1;
        rdata_i = (use_bad && raddr_o == bad_addr) ? word_bad : word_good;
    endtask

    initial begin
        int n, pulses, wrapped, last;
        logic [4:0] a;
        bit found;

        // Literal anchors for the model's encoder.
        check("enc_zero", enc(32'h0), 6'h2A);
        check("enc_one", enc(32'h1), 6'h33);

        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Clean sweep with immediate grants: full wrap through x31 back to x0.
        scrub_en_i = 1; interval_i = 0; port_gnt_i = 1;
        wrapped = 0; last = -1;
        for (int i = 0; i < 105; i++) begin
            tick();
            if (rreq_o) begin
                if (last == 31 && raddr_o == 5'd0) wrapped = 1;
                last = int'(raddr_o);
            end
        end
        check("sweep_wrapped", wrapped, 1);
        check("sweep_err_cnt", err_cnt_o, 8'd0);

        // Single data-bit flip at x5.
        use_bad = 1; found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if (err_o) found = 1;
        end
        use_bad = 0;
        check("flip_seen", found, 1);
        check("flip_alert", alert_major_o, 1);
        tick();
        check("flip_err_addr", err_addr_o, 5'd5);
        check("flip_err_cnt", err_cnt_o, 8'd1);

        // Grant stall with interval 4.
        interval_i = 4; port_gnt_i = 0;
        n = 0;
        while (!rreq_o && n < 40) begin tick(); n++; end
        check("stall_req_seen", rreq_o, 1);
        a = raddr_o;
        for (int i = 0; i < 10; i++) tick();
        check("stall_req_held", rreq_o, 1);
        check("stall_addr_held", raddr_o, a);
        port_gnt_i = 1;
        tick();
        port_gnt_i = 0;
        check("stall_in_check", rreq_o, 0);
        n = 0;
        while (!rreq_o && n < 50) begin tick(); n++; end
        check("stall_next_req_gap", n, 6);
        check("stall_next_addr", raddr_o, a + 5'd1);

        // Disable while requesting without a grant, then resume at the same address.
        a = raddr_o;
        scrub_en_i = 0;
        tick();
        check("dis_rreq_low", rreq_o, 0);
        tick();
        check("dis_ptr_kept", raddr_o, a);
        scrub_en_i = 1;
        n = 0;
        while (!rreq_o && n < 20) begin tick(); n++; end
        check("reen_req_seen", rreq_o, 1);
        check("reen_addr", raddr_o, a);

        // Continuous corrupt words: counter saturates, pulses continue.
        interval_i = 0; port_gnt_i = 1; word_good = 38'h0;
        pulses = 0;
        for (int i = 0; i < 1200 && pulses < 300; i++) begin
            tick();
            if (err_o) pulses++;
        end
        check("sat_pulses", pulses, 300);
        check("sat_err_cnt", err_cnt_o, 8'd255);

        // Reset during the check of an erroneous word.
        n = 0;
        while (!err_o && n < 20) begin tick(); n++; end
        check("rst_err_reached", err_o, 1);
        rst_n = 1'b0;
        #1;
        check("rst_err_o", err_o, 0);
        check("rst_alert", alert_major_o, 0);
        check("rst_rreq", rreq_o, 0);
        check("rst_raddr", raddr_o, 5'd0);
        check("rst_err_addr", err_addr_o, 5'd0);
        check("rst_err_cnt", err_cnt_o, 8'd0);
        scrub_en_i = 0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", rreq_o, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
